uart_tx_fifo: RTL

Synchronous byte FIFO that buffers transmit data between the APB register interface and the asynchronous UART transmitter when the core is built with the TX FIFO option enabled. Writes come from the bus-side TX data register strobe. The read side uses the transmitter's active-low single-cycle pop strobe and presents the popped byte on a registered output that stays stable until the next pop. The block also reports empty, full, level and a sticky overflow flag for the status register.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_fifo_ram.sv | 53 +++++
 rtl/uart_tx_fifo.sv | 119 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and helpers for the UART core.
//   UART_DATA_W            : width of a UART character (bits)
//   TX_FIFO_DEPTH_DEFAULT  : default number of entries in the TX FIFO
//   clog2()                : ceiling log2, used to derive pointer widths
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W           = 8;
  localparam int TX_FIFO_DEPTH_DEFAULT = 16;

  // Smallest n with 2**n >= value. Only ever evaluated at elaboration time.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_fifo_ram.sv
// -----------------------------------------------------------------------------
// uart_fifo_ram
// DEPTH x UART_DATA_W storage for the TX FIFO: one write port and one
// synchronous read port whose output register doubles as the FIFO's dout.
//   clk      in   clock
//   reset_n  in   async active-low reset (read register only)
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable (accepted pop)
//   raddr_i  in   read address
//   rdata_o  out  read register, holds until the next read
// -----------------------------------------------------------------------------
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH = TX_FIFO_DEPTH_DEFAULT,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   we_i,
  input  logic [AW-1:0]          waddr_i,
  input  logic [UART_DATA_W-1:0] wdata_i,
  input  logic                   re_i,
  input  logic [AW-1:0]          raddr_i,
  output logic [UART_DATA_W-1:0] rdata_o
);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];
  logic [UART_DATA_W-1:0] rdata_q;

  // NOTE: the array has no reset so it can map onto RAM or a plain register
  // file; it lives in its own always_ff, apart from the reset read register.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // NOTE: sequential state is assigned with <= so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : uart_fifo_ram

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Byte FIFO between the APB TX data register and the UART transmitter.
//   clk           in   system clock
//   reset_n       in   async active-low reset
//   flush         in   synchronous clear of pointers/count (dout, overflow kept)
//   wr_en         in   push strobe
//   wr_data       in   byte to push
//   fifo_read_n   in   active-low pop strobe from the transmitter
//   dout          out  last popped byte, held until the next accepted pop
//   fifo_empty    out  no entries stored
//   fifo_full     out  DEPTH entries stored
//   level         out  entry count 0..DEPTH
//   overflow      out  sticky: push attempted while full without a pop
//   clr_overflow  in   clears overflow (a same-cycle new overflow wins)
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = TX_FIFO_DEPTH_DEFAULT,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   fifo_read_n,
  output logic [UART_DATA_W-1:0] dout,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic [AW:0]            level,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          push_ok, pop_ok, ovf_set;

  // Accept logic. Emptiness is judged from the count before this cycle's
  // write, so a push into an empty FIFO never races a same-cycle read of the
  // same address.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    pop_ok  = 1'b0;
    push_ok = 1'b0;
    ovf_set = 1'b0;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      pop_ok  = !fifo_read_n && (cnt_q != '0);
      push_ok = wr_en && ((cnt_q != CNT_FULL) || pop_ok);
      ovf_set = wr_en && !push_ok;

      if (push_ok) wp_d = wp_q + AW'(1);
      if (pop_ok)  rp_d = rp_q + AW'(1);

      unique case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
        2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (clr_overflow) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  uart_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (push_ok),
    .waddr_i (wp_q),
    .wdata_i (wr_data),
    .re_i    (pop_ok),
    .raddr_i (rp_q),
    .rdata_o (dout)
  );

  // Status flags decode straight from the count register.
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_FULL);
  assign level      = cnt_q;
  assign overflow   = ovf_q;

endmodule : uart_tx_fifo
